alu_muldiv: RTL and testbench

Parametrised, registered integer ALU with an iterative unsigned multiply/divide engine for the pipelined MIPS-lite execute stage. It replaces per-bit ALU slices with a WIDTH-bit datapath. Single-cycle ops return in one clock. MULTU/DIVU run a WIDTH-step shift-add / restoring-divide sequence into HI/LO registers, with busy/done handshaking so the pipeline controller can stall EX.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_logic_unit.sv | 36 +++
 rtl/alu_muldiv.sv | 130 +++++++++++++
 tb/tb_alu_muldiv.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM state type and overflow helper shared by the ALU files
package alu_pkg;
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MFHI  = 4'b1101;
  localparam logic [3:0] OP_MFLO  = 4'b1110;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  // operand signs agree (B already inverted for SUB) but the sum sign differs
  function automatic logic signed_ovf(input logic sa, input logic sb, input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction
endpackage

// File: rtl/alu_logic_unit.sv
// alu_logic_unit: combinational logic/add/sub/compare slice with signed overflow
module alu_logic_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);
  logic             w_sub;
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_sum;
  logic             w_slt;
  logic             w_sltu;

  assign w_sub  = op == OP_SUB;
  assign w_bx   = w_sub ? ~b : b;
  assign w_sum  = a + w_bx + WIDTH'(w_sub);
  assign w_slt  = $signed(a) < $signed(b);
  assign w_sltu = a < b;

  // select the result of the requested op; unknown codes yield zero
  always_comb begin
    y = op == OP_AND  ? a & b :
        op == OP_OR   ? a | b :
        op == OP_NOR  ? ~(a | b) :
        op == OP_ADD  ? w_sum :
        op == OP_SUB  ? w_sum :
        op == OP_SLT  ? WIDTH'(w_slt) :
        op == OP_SLTU ? WIDTH'(w_sltu) : '0;
    ovf = (op == OP_ADD || op == OP_SUB) && signed_ovf(a[WIDTH-1], w_bx[WIDTH-1], w_sum[WIDTH-1]);
  end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: registered ALU with iterative unsigned multiply/divide into HI/LO
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_result, r_hi, r_lo;
  logic               r_zero, r_ovf, r_done, r_dbz;

  logic               w_accept, w_is_mul, w_is_div, w_divz, w_single, w_last;
  logic [WIDTH-1:0]   w_lu_y, w_res;
  logic               w_lu_ovf;
  logic [WIDTH:0]     w_mul_sum, w_div_sh;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_rem;
  logic [2*WIDTH-1:0] w_step;

  alu_logic_unit #(.WIDTH(WIDTH)) u_lu (
    .op (op),
    .a  (a),
    .b  (b),
    .y  (w_lu_y),
    .ovf(w_lu_ovf)
  );

  assign w_accept = start && r_state == IDLE;
  assign w_is_mul = op == OP_MULTU;
  assign w_is_div = op == OP_DIVU;
  assign w_divz   = w_is_div && b == '0;
  assign w_single = w_accept && !w_is_mul && !w_is_div;
  assign w_last   = r_cnt == CNT_W'(1);
  assign w_res    = op == OP_MFHI ? r_hi : op == OP_MFLO ? r_lo : w_lu_y;

  // r_acc holds {upper, lower}: product accumulator/multiplier for MUL,
  // {remainder, dividend->quotient} for DIV; r_op is multiplicand or divisor
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_op} : '0);
  assign w_div_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_ge  = w_div_sh >= {1'b0, r_op};
  assign w_div_rem = w_div_ge ? WIDTH'(w_div_sh - {1'b0, r_op}) : w_div_sh[WIDTH-1:0];
  assign w_step    = r_state == MUL ? {w_mul_sum, r_acc[WIDTH-1:1]}
                                    : {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // next-state: divide by zero completes in IDLE, iterations end on the last count
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !w_accept ? IDLE : w_is_mul ? MUL : (w_is_div && !w_divz) ? DIV : IDLE;
      MUL,
      DIV:     w_next = w_last ? IDLE : r_state;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = r_state != IDLE;
  end

  // datapath, counter, HI/LO and registered result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= w_single || (w_accept && w_divz) || (r_state != IDLE && w_last);
      if (w_accept) r_dbz <= w_divz;
      if (w_single) begin
        r_result <= w_res;
        r_zero   <= w_res == '0;
        r_ovf    <= w_lu_ovf;
      end
      if (w_accept && w_divz) begin
        r_lo <= '1;
        r_hi <= a;
      end
      if (w_accept && (w_is_mul || (w_is_div && !w_divz))) begin
        r_op  <= w_is_mul ? a : b;
        r_acc <= {{WIDTH{1'b0}}, w_is_mul ? b : a};
        r_cnt <= CNT_W'(WIDTH);
      end
      if (r_state != IDLE) begin
        r_acc <= w_step;
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_last) {r_hi, r_lo} <= w_step;
      end
    end
  end

  assign result      = r_result;
  assign zero        = r_zero;
  assign overflow    = r_ovf;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed checks of 8-bit and 32-bit alu_muldiv instances
module tb_alu_muldiv;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  logic        rst8_n, s8, z8, ov8, bsy8, dn8, dbz8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, r8, hi8, lo8;
  logic        rst32_n, s32, z32, ov32, bsy32, dn32, dbz32;
  logic [3:0]  op32;
  logic [31:0] a32, b32, r32, hi32, lo32;

  alu_muldiv #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst8_n), .start(s8), .op(op8), .a(a8), .b(b8),
    .result(r8), .zero(z8), .overflow(ov8), .busy(bsy8), .done(dn8),
    .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
  );

  alu_muldiv #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst32_n), .start(s32), .op(op32), .a(a32), .b(b32),
    .result(r32), .zero(z32), .overflow(ov32), .busy(bsy32), .done(dn32),
    .div_by_zero(dbz32), .hi(hi32), .lo(lo32)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    s8 = 1'b1; op8 = o; a8 = x; b8 = y;
    tick();
    s8 = 1'b0;
  endtask

  task automatic go32(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    s32 = 1'b1; op32 = o; a32 = x; b32 = y;
    tick();
    s32 = 1'b0;
  endtask

  initial begin
    rst8_n = 1'b0; s8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    rst32_n = 1'b0; s32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    tick(); tick();
    chk("rst_result", r8, 8'h00);
    chk("rst_zero", z8, 1);
    chk("rst_flags", {ov8, bsy8, dn8, dbz8}, 4'b0000);
    chk("rst_hilo", {hi8, lo8}, 16'h0000);
    @(negedge clk);
    rst8_n = 1'b1; rst32_n = 1'b1;

    go8(OP_ADD, 8'h7F, 8'h01);
    chk("add_result", r8, 8'h80);
    chk("add_ovf", ov8, 1);
    chk("add_zero", z8, 0);
    chk("add_done", dn8, 1);
    tick();
    chk("add_done_pulse", dn8, 0);

    go8(OP_SUB, 8'h55, 8'h55);
    chk("sub_result", r8, 8'h00);
    chk("sub_zero", z8, 1);
    chk("sub_ovf", ov8, 0);
    go8(OP_SUB, 8'h80, 8'h01);
    chk("sub_ovf_result", r8, 8'h7F);
    chk("sub_ovf_flag", ov8, 1);

    go8(OP_SLT, 8'hFF, 8'h01);
    chk("slt", r8, 8'h01);
    go8(OP_SLTU, 8'hFF, 8'h01);
    chk("sltu", r8, 8'h00);
    go8(OP_OR, 8'hA0, 8'h05);
    chk("or", r8, 8'hA5);
    go8(OP_NOR, 8'hF0, 8'h0C);
    chk("nor", r8, 8'h03);
    go8(4'b1111, 8'h12, 8'h34);
    chk("unknown_result", r8, 8'h00);
    chk("unknown_done", dn8, 1);

    go8(OP_MULTU, 8'hFF, 8'hFF);
    chk("mul_busy_0", bsy8, 1);
    chk("mul_done_0", dn8, 0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("mul_busy_%0d", i), {bsy8, dn8}, 2'b10);
      if (i == 2) begin s8 = 1'b1; op8 = OP_ADD; a8 = 8'd3; b8 = 8'd4; end
      if (i == 3) s8 = 1'b0;
    end
    tick();
    chk("mul_hi", hi8, 8'hFE);
    chk("mul_lo", lo8, 8'h01);
    chk("mul_done", {bsy8, dn8}, 2'b01);
    chk("mul_result_kept", r8, 8'h00);
    tick();
    chk("mul_done_pulse", dn8, 0);

    go8(OP_DIVU, 8'd200, 8'd7);
    chk("div_busy", bsy8, 1);
    for (int i = 1; i < 8; i++) tick();
    chk("div_pre_done", dn8, 0);
    tick();
    chk("div_lo", lo8, 8'd28);
    chk("div_hi", hi8, 8'd4);
    chk("div_done", {bsy8, dn8, dbz8}, 3'b010);

    go8(OP_DIVU, 8'd9, 8'd0);
    chk("dbz_lo", lo8, 8'hFF);
    chk("dbz_hi", hi8, 8'd9);
    chk("dbz_flags", {bsy8, dn8, dbz8}, 3'b011);
    tick();
    chk("dbz_sticky", {dn8, dbz8}, 2'b01);
    go8(OP_AND, 8'hF0, 8'h3C);
    chk("and", r8, 8'h30);
    chk("dbz_cleared", dbz8, 0);
    go8(OP_MFHI, 8'h00, 8'h00);
    chk("mfhi", r8, 8'd9);

    go32(OP_MULTU, 32'h0001_0003, 32'h0002_0005);
    for (int i = 1; i < 32; i++) tick();
    chk("mul32_busy_last", {bsy32, dn32}, 2'b10);
    tick();
    chk("mul32_hi", hi32, 32'h0000_0002);
    chk("mul32_lo", lo32, 32'h000B_000F);
    chk("mul32_done", {bsy32, dn32}, 2'b01);
    s32 = 1'b1; op32 = OP_MFLO;
    tick();
    s32 = 1'b0;
    chk("mflo_b2b", r32, 32'h000B_000F);
    chk("mflo_b2b_done", dn32, 1);

    go32(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0003);
    for (int i = 1; i < 5; i++) tick();
    chk("mul32_mid_busy", bsy32, 1);
    rst32_n = 1'b0;
    #1;
    chk("rst32_result", r32, 32'h0);
    chk("rst32_hilo", {hi32, lo32}, 64'h0);
    chk("rst32_flags", {z32, ov32, bsy32, dn32, dbz32}, 5'b10000);
    @(negedge clk);
    rst32_n = 1'b1;
    tick();
    chk("rst32_idle", {bsy32, dn32}, 2'b00);
    go32(OP_MFLO, 32'h0, 32'h0);
    chk("rst32_mflo", r32, 32'h0);
    chk("rst32_mflo_zero", z32, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
